// File: rtl/uart_tx_fifo_pkg.sv
// Shared definitions for the UART TX buffer.
//   UART_DATA_W      entry width, taken from the existing `DATA_WIDTH define
//   UART_FIFO_DEPTH  default number of entries
//   fifo_aw()        address width helper for a power-of-2 depth
`ifndef DATA_WIDTH
`define DATA_WIDTH 8
`endif

package uart_tx_fifo_pkg;

    localparam int UART_DATA_W     = `DATA_WIDTH;
    localparam int UART_FIFO_DEPTH = 16;

    function automatic int fifo_aw(input int depth);
        return $clog2(depth);
    endfunction

endpackage

// File: rtl/uart_fifo_mem.sv
// Storage array for the UART TX buffer: one synchronous write port and one
// asynchronous read port, so it maps onto distributed RAM.
// Ports:
//   clk    system clock
//   we     write enable
//   waddr  write address
//   wdata  write data
//   raddr  read address
//   rdata  read data, combinational from raddr
module uart_fifo_mem #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 16,
    parameter int AW     = 4
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);

    logic [DATA_W-1:0] mem [DEPTH];

    // No reset on the array: contents survive reset and are simply ignored
    // until pointers move past them again.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/uart_tx_fifo.sv
// TX buffer between the IO write path and the UART transmitter.
// First-word-fall-through: the head entry is always on rd_data. One entry is
// popped per rising edge of the transmitter's level read strobe rd_req.
// Ports:
//   clk          system clock
//   reset        synchronous, active-high
//   wr_en        push request, one cycle per byte
//   wr_data      byte to push
//   rd_req       transmitter read strobe (level; pops on 0->1)
//   ovf_clr      clears the sticky overflow/underflow flags
//   rd_data      head entry (don't-care while empty)
//   empty        no entries
//   full         count == DEPTH
//   almost_full  count >= AF_LVL
//   count        occupancy, 0..DEPTH
//   overflow     sticky: push dropped because the buffer was full
//   underflow    sticky: pop edge seen while empty
module uart_tx_fifo
    import uart_tx_fifo_pkg::*;
#(
    parameter int DATA_W = UART_DATA_W,
    parameter int DEPTH  = UART_FIFO_DEPTH,
    parameter int AF_LVL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [DATA_W-1:0]          wr_data,
    input  logic                       rd_req,
    input  logic                       ovf_clr,
    output logic [DATA_W-1:0]          rd_data,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [fifo_aw(DEPTH):0]    count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = fifo_aw(DEPTH);

    localparam logic [AW:0] ONE      = 1;
    localparam logic [AW:0] CNT_FULL = DEPTH[AW:0];
    localparam logic [AW:0] CNT_AF   = AF_LVL[AW:0];

    // Pointers carry one extra wrap bit and roll over mod 2*DEPTH.
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count_n;
    logic        rd_q;
    logic        pop;
    logic        push_ok;
    logic        pop_ok;
    logic        ovf_set;
    logic        udf_set;

    assign pop     = rd_req & ~rd_q;
    // A pop in the same cycle frees a slot, so a push into a full buffer is
    // still accepted when it coincides with a pop edge.
    assign push_ok = wr_en & (~full | pop);
    assign pop_ok  = pop & ~empty;
    assign ovf_set = wr_en & full & ~pop;
    assign udf_set = pop & empty;

    always_comb begin
        count_n = count;
        if (push_ok && !pop_ok) begin
            count_n = count + ONE;
        end else if (!push_ok && pop_ok) begin
            count_n = count - ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            count       <= '0;
            empty       <= 1'b1;
            full        <= 1'b0;
            almost_full <= 1'b0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            rd_q        <= 1'b0;
        end else begin
            rd_q <= rd_req;
            if (push_ok) begin
                wr_ptr <= wr_ptr + ONE;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + ONE;
            end
            count       <= count_n;
            empty       <= (count_n == '0);
            full        <= (count_n == CNT_FULL);
            almost_full <= (count_n >= CNT_AF);
            // Set wins over a clear in the same cycle.
            overflow    <= ovf_set | (overflow & ~ovf_clr);
            underflow   <= udf_set | (underflow & ~ovf_clr);
        end
    end

    uart_fifo_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (wr_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (rd_data)
    );

endmodule

// File: tb/tb_uart_tx_fifo.sv
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;
    localparam int AF    = 14;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_req;
    logic       ovf_clr;
    logic [7:0] rd_data;
    logic       empty;
    logic       full;
    logic       almost_full;
    logic [4:0] count;
    logic       overflow;
    logic       underflow;

    int checks = 0;
    int errors = 0;

    // Scoreboard: bytes expected to come out, in order.
    logic [7:0] exp_q[$];
    logic       m_prev = 1'b0;
    logic       m_ovf  = 1'b0;
    logic       m_udf  = 1'b0;

    always #5 clk = ~clk;

    uart_tx_fifo dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_req      (rd_req),
        .ovf_clr     (ovf_clr),
        .rd_data     (rd_data),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic check_status();
        check("count", 32'(count), 32'(exp_q.size()));
        check("empty", 32'(empty), 32'(exp_q.size() == 0));
        check("full", 32'(full), 32'(exp_q.size() == DEPTH));
        check("almost_full", 32'(almost_full), 32'(exp_q.size() >= AF));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("underflow", 32'(underflow), 32'(m_udf));
    endtask

    // One clock cycle. Inputs are applied 1 time unit after the previous
    // rising edge; popped data is compared before the edge that pops it,
    // status after it.
    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic c);
        logic m_pop;
        logic m_full;
        logic push_acc;
        wr_en   = w;
        wr_data = d;
        rd_req  = r;
        ovf_clr = c;
        m_pop   = r & ~m_prev;
        m_full  = (exp_q.size() == DEPTH);
        push_acc = w & (~m_full | m_pop);
        m_ovf = (w & m_full & ~m_pop) | (m_ovf & ~c);
        m_udf = (m_pop & (exp_q.size() == 0)) | (m_udf & ~c);
        #1;
        if (m_pop && exp_q.size() > 0) begin
            check("pop_data", 32'(rd_data), 32'(exp_q[0]));
            void'(exp_q.pop_front());
        end
        if (push_acc) exp_q.push_back(d);
        m_prev = r;
        @(posedge clk);
        #1;
        check_status();
    endtask

    task automatic do_reset(input logic w, input logic [7:0] d, input logic r);
        reset   = 1'b1;
        wr_en   = w;
        wr_data = d;
        rd_req  = r;
        ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        m_prev = 1'b0;
        m_ovf  = 1'b0;
        m_udf  = 1'b0;
        wr_en  = 1'b0;
        rd_req = 1'b0;
        check_status();
    endtask

    initial begin
        reset   = 1'b1;
        wr_en   = 1'b0;
        wr_data = 8'h00;
        rd_req  = 1'b0;
        ovf_clr = 1'b0;
        @(posedge clk);
        #1;
        do_reset(1'b0, 8'h00, 1'b0);

        // 1: three consecutive pushes
        cyc(1'b1, 8'h48, 1'b0, 1'b0);
        check("t1_first_visible", 32'(rd_data), 32'h48);
        cyc(1'b1, 8'h65, 1'b0, 1'b0);
        cyc(1'b1, 8'h6C, 1'b0, 1'b0);
        check("t1_count", 32'(count), 32'd3);
        check("t1_empty", 32'(empty), 32'd0);
        check("t1_rd_data", 32'(rd_data), 32'h48);

        // 2: long read strobe pops once
        for (int i = 0; i < 400; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_rd_data", 32'(rd_data), 32'h65);
        check("t2_count", 32'(count), 32'd2);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        check("t2_second_pop", 32'(rd_data), 32'h6C);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        check("t2_drained", 32'(empty), 32'd1);

        // 3: fill, overflow, drain
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        check("t3_full", 32'(full), 32'd1);
        check("t3_almost_full", 32'(almost_full), 32'd1);
        cyc(1'b1, 8'hAA, 1'b0, 1'b0);
        check("t3_overflow", 32'(overflow), 32'd1);
        check("t3_count", 32'(count), 32'd16);
        for (int i = 0; i < 16; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("t3_empty_after_drain", 32'(empty), 32'd1);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t3_ovf_cleared", 32'(overflow), 32'd0);

        // 4: push and pop edge together while full
        for (int i = 0; i < 16; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
        cyc(1'b1, 8'hBB, 1'b1, 1'b0);
        check("t4_count", 32'(count), 32'd16);
        check("t4_overflow", 32'(overflow), 32'd0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            if (i == 15) check("t4_last_out", 32'(rd_data), 32'hBB);
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("t4_empty", 32'(empty), 32'd1);

        // 5: pop edge with push while empty
        cyc(1'b1, 8'h5A, 1'b1, 1'b0);
        check("t5_underflow", 32'(underflow), 32'd1);
        check("t5_count", 32'(count), 32'd1);
        check("t5_rd_data", 32'(rd_data), 32'h5A);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        check("t5_udf_cleared", 32'(underflow), 32'd0);
        check("t5_ovf_cleared", 32'(overflow), 32'd0);

        // 6: wrap pointers, then reset mid-stream
        for (int i = 0; i < 4; i++) cyc(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
        check("t6_count5", 32'(count), 32'd5);
        for (int i = 0; i < 40; i++) begin
            cyc(1'b1, 8'($urandom_range(0, 255)), 1'b1, 1'b0);
            cyc(1'b0, 8'h00, 1'b0, 1'b0);
        end
        check("t6_count_kept", 32'(count), 32'd5);
        do_reset(1'b1, 8'hEE, 1'b1);
        check("t6_rst_count", 32'(count), 32'd0);
        check("t6_rst_empty", 32'(empty), 32'd1);
        check("t6_rst_flags", 32'({overflow, underflow, full, almost_full}), 32'd0);
        cyc(1'b1, 8'h21, 1'b0, 1'b0);
        check("t6_readback", 32'(rd_data), 32'h21);
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
